// File: rtl/inst_executor.sv
`default_nettype none
// ============================================================================
// Module   : inst_executor
// Purpose  : Synchronizes decoder command pulses and runs the acquisition
//            window and tagged channel readout sequence.
// Revision : 1.0 - initial release
// ============================================================================
module inst_executor #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 8,
    parameter int SAMPLE_BITS = 10,
    parameter int ACQ_CYCLES  = 64,
    localparam int CHW        = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inst_rst,
    input  logic                       inst_readout,
    input  logic                       inst_start,
    output logic                       sample_en,
    output logic [CHW-1:0]             ch_sel,
    input  logic [SAMPLE_BITS-1:0]     ch_data,
    output logic [CHW+SAMPLE_BITS-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       rd_done,
    output logic                       busy,
    output logic [7:0]                 status
);

    localparam int ACQW = $clog2(ACQ_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        HOLD = 2'd2,
        READ = 2'd3
    } state_t;

    // Each synchronizer row carries {start, readout, rst}; row SYNC_STAGES-1 is the oldest.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  prev_q;
    logic [2:0]                  cmd;
    logic                        cmd_rst, cmd_rd, cmd_start;

    state_t                       state_q, state_d;
    logic                         err_q, err_d;
    logic                         hold_valid_q, hold_valid_d;
    logic                         sample_en_q, sample_en_d;
    logic [CHW-1:0]               ch_sel_q, ch_sel_d;
    logic [CHW+SAMPLE_BITS-1:0]   out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         rd_done_q, rd_done_d;
    logic                         busy_q, busy_d;
    logic [ACQW-1:0]              acq_cnt_q, acq_cnt_d;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], inst_start, inst_readout, inst_rst};
    assign cmd       = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign cmd_rst   = cmd[0];
    assign cmd_rd    = cmd[1];
    assign cmd_start = cmd[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            prev_q       <= '0;
            state_q      <= IDLE;
            err_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            sample_en_q  <= 1'b0;
            ch_sel_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            rd_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            acq_cnt_q    <= '0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= sync_q[SYNC_STAGES-1];
            state_q      <= state_d;
            err_q        <= err_d;
            hold_valid_q <= hold_valid_d;
            sample_en_q  <= sample_en_d;
            ch_sel_q     <= ch_sel_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            rd_done_q    <= rd_done_d;
            busy_q       <= busy_d;
            acq_cnt_q    <= acq_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        hold_valid_d = hold_valid_q;
        sample_en_d  = sample_en_q;
        ch_sel_d     = ch_sel_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        rd_done_d    = 1'b0;
        acq_cnt_d    = acq_cnt_q;

        if (cmd_rst) begin
            state_d      = IDLE;
            err_d        = 1'b0;
            hold_valid_d = 1'b0;
            sample_en_d  = 1'b0;
            out_valid_d  = 1'b0;
            ch_sel_d     = '0;
            acq_cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_rd) begin
                        err_d = 1'b1;
                    end else if (cmd_start) begin
                        state_d     = ACQ;
                        sample_en_d = 1'b1;
                        acq_cnt_d   = '0;
                    end
                end
                ACQ: begin
                    if (cmd_rd || cmd_start) begin
                        err_d = 1'b1;
                    end
                    if (acq_cnt_q == ACQW'(ACQ_CYCLES - 1)) begin
                        state_d      = HOLD;
                        sample_en_d  = 1'b0;
                        hold_valid_d = 1'b1;
                        acq_cnt_d    = '0;
                    end else begin
                        acq_cnt_d = acq_cnt_q + ACQW'(1);
                    end
                end
                HOLD: begin
                    if (cmd_rd) begin
                        state_d     = READ;
                        ch_sel_d    = '0;
                        out_valid_d = 1'b0;
                    end else if (cmd_start) begin
                        state_d      = ACQ;
                        hold_valid_d = 1'b0;
                        sample_en_d  = 1'b1;
                        acq_cnt_d    = '0;
                    end
                end
                READ: begin
                    if (cmd_rd || cmd_start) begin
                        err_d = 1'b1;
                    end
                    // Mux data is settled one cycle after ch_sel moves, so a word is
                    // captured only in the cycle that follows each channel advance.
                    if (!out_valid_q) begin
                        out_data_d  = {ch_sel_q, ch_data};
                        out_valid_d = 1'b1;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (ch_sel_q == CHW'(NUM_CH - 1)) begin
                            rd_done_d    = 1'b1;
                            ch_sel_d     = '0;
                            hold_valid_d = 1'b0;
                            state_d      = IDLE;
                        end else begin
                            ch_sel_d = ch_sel_q + CHW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == ACQ) || (state_d == READ);
    end

    assign sample_en = sample_en_q;
    assign ch_sel    = ch_sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign rd_done   = rd_done_q;
    assign busy      = busy_q;
    assign status    = {err_q, 3'b000, hold_valid_q, busy_q, state_q};

endmodule
`default_nettype wire

// File: doc/inst_executor.md
Name: inst_executor

Overview:
- Command-side responder to the instruction decoder. It consumes the level pulses `inst_rst`, `inst_readout` and `inst_start`, which are generated while `csb` is high after an instruction write and are asynchronous to `clk`.
- It synchronizes and edge-detects those pulses, then runs the acquisition/readout sequence.
  - On start: holds `sample_en` for a fixed window.
  - On readout: walks all channels through the sample mux and streams tagged words out over a valid/ready handshake.
- It reports state and a sticky command-error flag back for SPI status readback.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer; minimum 2.
- NUM_CH, 8, number of channels read out per readout command; minimum 2.
- SAMPLE_BITS, 10, width of one channel sample.
- ACQ_CYCLES, 64, clk cycles `sample_en` is held high per start command; minimum 1.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inst_rst` input 1: async reset-command pulse from the instruction decoder.
- `inst_readout` input 1: async readout-command pulse.
- `inst_start` input 1: async start-command pulse.
- `sample_en` output 1: acquisition window enable to the sampling array.
- `ch_sel` output CHW=$clog2(NUM_CH): channel select to the sample mux.
- `ch_data` input SAMPLE_BITS: mux output for `ch_sel`; valid one cycle after `ch_sel` changes.
- `out_data` output CHW+SAMPLE_BITS: {channel index, sample}.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: consumer accepts the word.
- `rd_done` output 1: one-cycle pulse after the last channel is accepted.
- `busy` output 1: high in ACQ or READ.
- `status` output 8: {err, 3'b0, hold_valid, busy, state[1:0]}.

Behaviour:
- Reset (`rst`=1 at an edge): state=IDLE, all synchronizer flops and edge-detect flops =0. All outputs (`sample_en`, `ch_sel`, `out_data`, `out_valid`, `rd_done`, `busy`, err, hold_valid) =0.
- Synchronizer and edge detect:
  - Each inst_* input passes through SYNC_STAGES flops, then a previous-value flop.
  - The command strobe cmd_x = sync_out & ~prev, high for exactly one cycle per rising edge.
  - The first edge sampling the input high is edge E. cmd_x is high in the cycle after edge E+SYNC_STAGES-1. The resulting state change is visible after edge E+SYNC_STAGES.
  - A level held high for many cycles yields exactly one strobe.
- Priority when strobes coincide: rst > readout > start. Lower-priority strobes in the same cycle are dropped and do not set err.
- States: IDLE=0, ACQ=1, HOLD=2, READ=3.
- cmd_rst in any state:
  - Next state IDLE.
  - Clears err and hold_valid, `sample_en`=0, `out_valid`=0, `ch_sel`=0, counters=0.
  - Aborts ACQ/READ mid-operation.
- IDLE:
  - start -> ACQ, acq counter=0.
  - readout -> err=1, stay IDLE.
- ACQ:
  - `sample_en`=1 for exactly ACQ_CYCLES cycles, then -> HOLD with hold_valid=1 and `sample_en`=0.
  - start or readout during ACQ -> err=1, ignored.
- HOLD:
  - start -> ACQ (re-arms; hold_valid cleared).
  - readout -> READ, `ch_sel`=0.
- READ, per channel:
  - Fetch cycle (`out_valid`=0): at the end of the cycle, latch {`ch_sel`, `ch_data`} into `out_data` and set `out_valid`=1.
  - While `out_valid`=1 and `out_ready`=0: `out_data` and `ch_sel` held stable.
  - On an edge with `out_valid`&&`out_ready`, if `ch_sel`<NUM_CH-1: `ch_sel`++, `out_valid`=0, next fetch.
  - On that edge, if `ch_sel`=NUM_CH-1: `rd_done`=1 for one cycle, `out_valid`=0, `ch_sel`=0, hold_valid=0, -> IDLE.
  - Throughput with `out_ready` tied high: one word every 2 cycles; NUM_CH words total.
  - start or readout during READ -> err=1, ignored.
- `busy` = state is ACQ or READ (registered with state).
- err is sticky; cleared only by cmd_rst or `rst`.

Test Plan:
- `rst`, then pulse `inst_start` 5 cycles -> exactly one strobe; `sample_en` high exactly 64 cycles starting SYNC_STAGES+1 edges after first capture; `status`=8'h0A (HOLD, hold_valid).
- From HOLD, pulse `inst_readout`, `ch_data`=ch_sel*3, `out_ready`=1 -> 8 words {0,0},{1,3}…{7,21} at 2-cycle spacing; `rd_done` pulses once; `status`=8'h00.
- During READ, hold `out_ready`=0 for 10 cycles at channel 4 -> `out_data`={4,12} stable, `out_valid`=1 throughout; the stream resumes at ch5 once ready.
- `inst_readout` while IDLE, then `inst_start` during ACQ -> err=1 (`status`[7]=1); ACQ window unaffected; later `inst_rst` -> `status`=8'h00.
- `inst_rst` and `inst_start` rising on the same edge while IDLE -> stays IDLE, `sample_en` never asserts, err=0.
- Assert `inst_rst` mid-READ at channel 3 with `out_valid`=1 -> `out_valid`=0, `ch_sel`=0, IDLE; no `rd_done`.
